// File: rtl/sparc_exu_alu_rdpipe.sv
// Purpose : M/W result pipeline behind the EXU ALU. It feeds M/W bypass data to the rs1/rs2 operand muxes and drives the IRF write port.
// Latency : an E result is bypassable in M at n+1 and written back from W at n+2. Bypass and write-back outputs are combinational from state.
// Backpr. : ecl_stall freezes M and W and ignores E. A W entry held by a stall writes once, on the first unstalled cycle.
//
// Ports:
//   rclk, reset                         clock, synchronous active-high reset
//   alu_byp_rd_data_e, ecl_rd_e,
//   ecl_tid_e, ecl_wen_e                E-stage result, destination tag, thread and write enable
//   ecl_kill_e, ecl_kill_m, ecl_stall   squash E / squash M (same cycle) / freeze M and W
//   byp_rs{1,2}_tag, byp_rs{1,2}_tid    D-stage source lookups
//   rdp_rs{1,2}_hit, rdp_rs{1,2}_data   bypass result (data is 0 when there is no hit)
//   rdp_wb_wen/rd/tid/data              register-file write port, driven from the W stage
module sparc_exu_alu_rdpipe #(
    parameter int DW = 64,
    parameter int TW = 2
) (
    input  logic          rclk,
    input  logic          reset,
    input  logic [DW-1:0] alu_byp_rd_data_e,
    input  logic [4:0]    ecl_rd_e,
    input  logic [TW-1:0] ecl_tid_e,
    input  logic          ecl_wen_e,
    input  logic          ecl_kill_e,
    input  logic          ecl_kill_m,
    input  logic          ecl_stall,
    input  logic [4:0]    byp_rs1_tag,
    input  logic [4:0]    byp_rs2_tag,
    input  logic [TW-1:0] byp_rs1_tid,
    input  logic [TW-1:0] byp_rs2_tid,
    output logic          rdp_rs1_hit,
    output logic          rdp_rs2_hit,
    output logic [DW-1:0] rdp_rs1_data,
    output logic [DW-1:0] rdp_rs2_data,
    output logic          rdp_wb_wen,
    output logic [4:0]    rdp_wb_rd,
    output logic [TW-1:0] rdp_wb_tid,
    output logic [DW-1:0] rdp_wb_data
);

    // M stage
    logic          m_vld_q, m_vld_d;
    logic [4:0]    m_rd_q,  m_rd_d;
    logic [TW-1:0] m_tid_q, m_tid_d;
    logic [DW-1:0] m_dat_q, m_dat_d;
    // W stage
    logic          w_vld_q, w_vld_d;
    logic [4:0]    w_rd_q,  w_rd_d;
    logic [TW-1:0] w_tid_q, w_tid_d;
    logic [DW-1:0] w_dat_q, w_dat_d;

    // M valid after a same-cycle kill. This value feeds both the bypass and the M->W advance.
    logic m_eff_vld;
    assign m_eff_vld = m_vld_q & ~ecl_kill_m;

    always_comb begin
        m_vld_d = m_vld_q;
        m_rd_d  = m_rd_q;
        m_tid_d = m_tid_q;
        m_dat_d = m_dat_q;
        w_vld_d = w_vld_q;
        w_rd_d  = w_rd_q;
        w_tid_d = w_tid_q;
        w_dat_d = w_dat_q;
        if (ecl_stall) begin
            // Everything holds. The one exception is that a kill still clears the held M entry.
            m_vld_d = m_eff_vld;
        end else begin
            // r0 is never a valid destination. This also keeps tag 0 from ever producing a bypass hit.
            m_vld_d = ecl_wen_e & ~ecl_kill_e & (ecl_rd_e != 5'd0);
            m_rd_d  = ecl_rd_e;
            m_tid_d = ecl_tid_e;
            m_dat_d = alu_byp_rd_data_e;
            w_vld_d = m_eff_vld;
            w_rd_d  = m_rd_q;
            w_tid_d = m_tid_q;
            w_dat_d = m_dat_q;
        end
    end

    always_ff @(posedge rclk) begin
        if (reset) begin
            m_vld_q <= 1'b0;
            m_rd_q  <= '0;
            m_tid_q <= '0;
            m_dat_q <= '0;
            w_vld_q <= 1'b0;
            w_rd_q  <= '0;
            w_tid_q <= '0;
            w_dat_q <= '0;
        end else begin
            m_vld_q <= m_vld_d;
            m_rd_q  <= m_rd_d;
            m_tid_q <= m_tid_d;
            m_dat_q <= m_dat_d;
            w_vld_q <= w_vld_d;
            w_rd_q  <= w_rd_d;
            w_tid_q <= w_tid_d;
            w_dat_q <= w_dat_d;
        end
    end

    // M is the younger producer, so an M match wins over a W match.
    logic m_hit1, w_hit1, m_hit2, w_hit2;
    assign m_hit1 = m_eff_vld & (m_rd_q == byp_rs1_tag) & (m_tid_q == byp_rs1_tid);
    assign w_hit1 = w_vld_q   & (w_rd_q == byp_rs1_tag) & (w_tid_q == byp_rs1_tid);
    assign m_hit2 = m_eff_vld & (m_rd_q == byp_rs2_tag) & (m_tid_q == byp_rs2_tid);
    assign w_hit2 = w_vld_q   & (w_rd_q == byp_rs2_tag) & (w_tid_q == byp_rs2_tid);

    assign rdp_rs1_hit  = m_hit1 | w_hit1;
    assign rdp_rs2_hit  = m_hit2 | w_hit2;
    assign rdp_rs1_data = m_hit1 ? m_dat_q : (w_hit1 ? w_dat_q : '0);
    assign rdp_rs2_data = m_hit2 ? m_dat_q : (w_hit2 ? w_dat_q : '0);

    // A stalled W entry is held and not written. It writes on the first unstalled cycle and then advances out of W.
    assign rdp_wb_wen  = w_vld_q & ~ecl_stall;
    assign rdp_wb_rd   = w_rd_q;
    assign rdp_wb_tid  = w_tid_q;
    assign rdp_wb_data = w_dat_q;

endmodule

// File: tb/tb_sparc_exu_alu_rdpipe.sv
module tb_sparc_exu_alu_rdpipe;

    localparam int DW = 64;
    localparam int TW = 2;

    logic          rclk;
    logic          reset;
    logic [DW-1:0] alu_byp_rd_data_e;
    logic [4:0]    ecl_rd_e;
    logic [TW-1:0] ecl_tid_e;
    logic          ecl_wen_e, ecl_kill_e, ecl_kill_m, ecl_stall;
    logic [4:0]    byp_rs1_tag, byp_rs2_tag;
    logic [TW-1:0] byp_rs1_tid, byp_rs2_tid;
    logic          rdp_rs1_hit, rdp_rs2_hit;
    logic [DW-1:0] rdp_rs1_data, rdp_rs2_data;
    logic          rdp_wb_wen;
    logic [4:0]    rdp_wb_rd;
    logic [TW-1:0] rdp_wb_tid;
    logic [DW-1:0] rdp_wb_data;

    sparc_exu_alu_rdpipe #(.DW(DW), .TW(TW)) dut (
        .rclk              (rclk),
        .reset             (reset),
        .alu_byp_rd_data_e (alu_byp_rd_data_e),
        .ecl_rd_e          (ecl_rd_e),
        .ecl_tid_e         (ecl_tid_e),
        .ecl_wen_e         (ecl_wen_e),
        .ecl_kill_e        (ecl_kill_e),
        .ecl_kill_m        (ecl_kill_m),
        .ecl_stall         (ecl_stall),
        .byp_rs1_tag       (byp_rs1_tag),
        .byp_rs2_tag       (byp_rs2_tag),
        .byp_rs1_tid       (byp_rs1_tid),
        .byp_rs2_tid       (byp_rs2_tid),
        .rdp_rs1_hit       (rdp_rs1_hit),
        .rdp_rs2_hit       (rdp_rs2_hit),
        .rdp_rs1_data      (rdp_rs1_data),
        .rdp_rs2_data      (rdp_rs2_data),
        .rdp_wb_wen        (rdp_wb_wen),
        .rdp_wb_rd         (rdp_wb_rd),
        .rdp_wb_tid        (rdp_wb_tid),
        .rdp_wb_data       (rdp_wb_data)
    );

    initial rclk = 1'b0;
    always #5 rclk = ~rclk;

    typedef struct {
        int          wen, rd, tid;
        logic [63:0] dat;
        int          ke, km, st;
        int          t1, i1, t2, i2;
        int          h1;
        logic [63:0] d1;
        int          h2;
        logic [63:0] d2;
        int          ww, wrd, wtid;
        logic [63:0] wd;
    } vec_t;

    int n_vec  = 0;
    int n_miss = 0;

    function automatic vec_t mk(int wen, int rd, int tid, logic [63:0] dat, int ke, int km, int st,
                                int t1, int i1, int t2, int i2,
                                int h1, logic [63:0] d1, int h2, logic [63:0] d2,
                                int ww, int wrd, int wtid, logic [63:0] wd);
        vec_t v;
        v.wen = wen; v.rd = rd; v.tid = tid; v.dat = dat;
        v.ke = ke; v.km = km; v.st = st;
        v.t1 = t1; v.i1 = i1; v.t2 = t2; v.i2 = i2;
        v.h1 = h1; v.d1 = d1; v.h2 = h2; v.d2 = d2;
        v.ww = ww; v.wrd = wrd; v.wtid = wtid; v.wd = wd;
        return v;
    endfunction

    task automatic drv(input int wen, input int rd, input int tid, input logic [63:0] dat,
                       input int ke, input int km, input int st,
                       input int t1, input int i1, input int t2, input int i2);
        ecl_wen_e         = 1'(wen);
        ecl_rd_e          = 5'(rd);
        ecl_tid_e         = TW'(tid);
        alu_byp_rd_data_e = dat;
        ecl_kill_e        = 1'(ke);
        ecl_kill_m        = 1'(km);
        ecl_stall         = 1'(st);
        byp_rs1_tag       = 5'(t1);
        byp_rs1_tid       = TW'(i1);
        byp_rs2_tag       = 5'(t2);
        byp_rs2_tid       = TW'(i2);
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic chkall(input string tag, input int h1, input logic [63:0] d1,
                          input int h2, input logic [63:0] d2,
                          input int ww, input int wrd, input int wtid, input logic [63:0] wd);
        chk({tag, " rs1_hit"},  64'(rdp_rs1_hit),  64'(h1));
        chk({tag, " rs1_data"}, rdp_rs1_data,      d1);
        chk({tag, " rs2_hit"},  64'(rdp_rs2_hit),  64'(h2));
        chk({tag, " rs2_data"}, rdp_rs2_data,      d2);
        chk({tag, " wb_wen"},   64'(rdp_wb_wen),   64'(ww));
        chk({tag, " wb_rd"},    64'(rdp_wb_rd),    64'(wrd));
        chk({tag, " wb_tid"},   64'(rdp_wb_tid),   64'(wtid));
        chk({tag, " wb_data"},  rdp_wb_data,       wd);
    endtask

    // Inputs are applied 1 time unit after a rising edge, and outputs are sampled 2 units later, well before the next edge.
    task automatic tick();
        @(posedge rclk);
        #1;
    endtask

    initial begin
        vec_t tbl[$];

        // Each row is one cycle. Its expectations describe the state left by the rows before it.
        tbl.push_back(mk(1,5,1,64'hDEADBEEF,0,0,0, 5,1,5,0, 0,64'h0,0,64'h0, 0,0,0,64'h0));            // reset state, E rd5
        tbl.push_back(mk(0,0,0,64'h0,0,0,0,        5,1,5,0, 1,64'hDEADBEEF,0,64'h0, 0,0,0,64'h0));     // rd5 in M: hit
        tbl.push_back(mk(1,7,0,64'h1,0,0,0,        5,1,7,0, 1,64'hDEADBEEF,0,64'h0, 1,5,1,64'hDEADBEEF)); // rd5 in W: write
        tbl.push_back(mk(1,7,0,64'h2,0,0,0,        0,0,7,0, 0,64'h0,1,64'h1, 0,0,0,64'h0));             // rd7=1 in M
        tbl.push_back(mk(1,3,0,64'h33,1,0,0,       7,0,7,0, 1,64'h2,1,64'h2, 1,7,0,64'h1));             // M over W; kill_e rd3
        tbl.push_back(mk(1,0,0,64'h44,0,0,0,       3,0,7,0, 0,64'h0,1,64'h2, 1,7,0,64'h2));             // killed rd3 no hit; rd0 in E
        tbl.push_back(mk(1,4,3,64'h4444,0,0,0,     3,0,0,0, 0,64'h0,0,64'h0, 0,3,0,64'h33));            // killed rd3 in W: no write
        tbl.push_back(mk(1,9,2,64'h99,0,1,0,       4,3,4,3, 0,64'h0,0,64'h0, 0,0,0,64'h44));            // kill_m rd4; rd0 no write
        tbl.push_back(mk(0,0,0,64'h0,0,0,0,        9,0,9,2, 0,64'h0,1,64'h99, 0,4,3,64'h4444));         // tid isolation; rd4 no write
        tbl.push_back(mk(0,0,0,64'h0,0,0,0,        9,2,4,3, 1,64'h99,0,64'h0, 1,9,2,64'h99));           // rd9 W hit + write
        tbl.push_back(mk(0,0,0,64'h0,0,0,0,        0,0,0,0, 0,64'h0,0,64'h0, 0,0,0,64'h0));             // drained; tag0 never hits

        reset = 1'b1;
        drv(0,0,0,64'h0,0,0,0, 0,0,0,0);
        repeat (2) @(posedge rclk);
        #1;
        reset = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            drv(tbl[i].wen, tbl[i].rd, tbl[i].tid, tbl[i].dat, tbl[i].ke, tbl[i].km, tbl[i].st,
                tbl[i].t1, tbl[i].i1, tbl[i].t2, tbl[i].i2);
            #2;
            chkall($sformatf("vec%0d", i), tbl[i].h1, tbl[i].d1, tbl[i].h2, tbl[i].d2,
                   tbl[i].ww, tbl[i].wrd, tbl[i].wtid, tbl[i].wd);
            tick();
        end

        // Stall with W={6,1,0x66} and M={8,0,0x88}. A kill lands on the held M, and E input is ignored while stalled.
        drv(1,6,1,64'h66,0,0,0, 0,0,0,0); tick();
        drv(1,8,0,64'h88,0,0,0, 0,0,0,0); tick();
        drv(1,10,0,64'hAA,0,0,1, 8,0,6,1); #2;
        chkall("stall1", 1,64'h88, 1,64'h66, 0,6,1,64'h66); tick();
        drv(1,10,0,64'hAA,0,1,1, 8,0,6,1); #2;
        chkall("stall2_killm", 0,64'h0, 1,64'h66, 0,6,1,64'h66); tick();
        drv(1,10,0,64'hAA,0,0,1, 8,0,10,0); #2;
        chkall("stall3", 0,64'h0, 0,64'h0, 0,6,1,64'h66); tick();
        drv(0,0,0,64'h0,0,0,0, 8,0,10,0); #2;
        chkall("release", 0,64'h0, 0,64'h0, 1,6,1,64'h66); tick();
        drv(0,0,0,64'h0,0,0,0, 8,0,10,0); #2;
        chkall("after_release", 0,64'h0, 0,64'h0, 0,8,0,64'h88); tick();

        // Reset with M and W both valid. Reset also has priority over a concurrent stall.
        drv(1,11,1,64'hBB,0,0,0, 0,0,0,0); tick();
        drv(1,12,1,64'hCC,0,0,0, 0,0,0,0); tick();
        drv(1,13,1,64'hDD,0,0,1, 12,1,11,1); #2;
        chkall("pre_reset", 1,64'hCC, 1,64'hBB, 0,11,1,64'hBB);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        drv(0,0,0,64'h0,0,0,0, 12,1,11,1); #2;
        chkall("post_reset", 0,64'h0, 0,64'h0, 0,0,0,64'h0); tick();
        drv(0,0,0,64'h0,0,0,0, 13,1,11,1); #2;
        chkall("post_reset2", 0,64'h0, 0,64'h0, 0,0,0,64'h0); tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/sparc_exu_alu_rdpipe.md
# sparc_exu_alu_rdpipe

Result pipeline directly downstream of the EXU ALU. It captures the ALU result in E (`alu_byp_rd_data_e`) together with its destination tag and thread id, and carries it through the M and W stages. It supplies M/W bypass data to the rs1/rs2 operand muxes and drives the integer register-file write port in W. Pipeline state is two register stages (M, W) with valid bits, stall hold and per-stage kill.

## Interface
Parameters:
- `DW`, 64: result data width.
- `TW`, 2: thread-id width.

Ports:
- `rclk` in 1: clock. All state updates on the rising edge.
- `reset` in 1: synchronous, active-high reset.
- `alu_byp_rd_data_e` in DW: ALU result in E.
- `ecl_rd_e` in 5: destination register tag in E.
- `ecl_tid_e` in TW: thread id in E.
- `ecl_wen_e` in 1: the E instruction writes rd.
- `ecl_kill_e` in 1: squash the E instruction; it does not enter M as valid.
- `ecl_kill_m` in 1: squash the M instruction, effective this cycle.
- `ecl_stall` in 1: freeze the M and W stages; the E input is ignored.
- `byp_rs1_tag`, `byp_rs2_tag` in 5 each: source tags in D.
- `byp_rs1_tid`, `byp_rs2_tid` in TW each: source thread ids in D.
- `rdp_rs1_hit`, `rdp_rs2_hit` out 1 each: a bypass match was found.
- `rdp_rs1_data`, `rdp_rs2_data` out DW each: bypassed operand.
- `rdp_wb_wen` out 1: register-file write enable.
- `rdp_wb_rd` out 5: write-back register tag.
- `rdp_wb_tid` out TW: write-back thread id.
- `rdp_wb_data` out DW: write-back data.

## Operation
State per stage: `vld`, `rd[4:0]`, `tid`, `data[DW-1:0]`, for M and W.

Advance, when `ecl_stall`=0:
- M.vld <= `ecl_wen_e` & ~`ecl_kill_e` & (`ecl_rd_e` != 0). Register 0 is never valid.
- M.rd/tid/data <= E inputs. They load regardless of valid.
- W <= M, with W.vld <= M.vld & ~`ecl_kill_m`.

Stall, when `ecl_stall`=1:
- M and W hold their contents.
- The only exception: M.vld <= M.vld & ~`ecl_kill_m`. A kill during a stall clears the held M.

Effective M valid: `mv` = M.vld & ~`ecl_kill_m`.

Bypass, combinational from registered state and source inputs, per port x in {rs1, rs2}:
- M hit: `mv` & M.rd==tag & M.tid==tid.
- W hit: W.vld & W.rd==tag & W.tid==tid.
- Priority is M over W, because M is the younger instruction.
- `rdp_x_hit` = M hit | W hit.
- `rdp_x_data` = M.data on an M hit, else W.data on a W hit, else 0.
- A tag of 0 never hits, which follows from the valid rule.

Write-back:
- `rdp_wb_wen` = W.vld & ~`ecl_stall`.
- `rdp_wb_rd`, `rdp_wb_tid` and `rdp_wb_data` always drive W contents.
- A W entry held by a stall writes exactly once, in the first cycle after the stall is released.

Reset: all vld, rd, tid and data registers clear to 0. All outputs are therefore 0 during and after reset until new E inputs arrive.

## Timing
- An E instruction at cycle n (no stall) is in M at n+1 and visible to bypass in that cycle. It is in W at n+2, with `rdp_wb_wen`=1 at n+2.
- Bypass and `rdp_wb_*` are purely combinational from state plus the current-cycle `byp_*` and `ecl_kill_m`/`ecl_stall`. There is no extra latency.
- Kill in E or M takes effect the same cycle as the kill. It suppresses the M bypass immediately. A killed instruction never produces `rdp_wb_wen`.
- `reset` asserted mid-operation clears all in-flight entries on that edge. It takes priority over stall and advance.
- With stall and advance back to back, at most one entry occupies each stage. No data is lost, because E is held by the upstream stall.

## Test plan
- Single write: E rd=5, tid=1, data=0xDEAD_BEEF, wen=1 at cycle 0.
  - Cycle 2: `rdp_wb_wen`=1, rd=5, tid=1, data=0xDEADBEEF.
  - Cycle 1: query rs1 tag 5/tid 1 -> hit, data 0xDEADBEEF.
- M/W priority: rd=7 data=0x1 at cycle 0, then rd=7 data=0x2 at cycle 1. At cycle 2, rs2 tag 7 -> hit with data 0x2 (from M), while W holds 0x1 and is writing it.
- Kill and r0:
  - `ecl_kill_e` with rd=3 -> no hit and no write, ever.
  - rd=0 with wen=1 -> no hit and no write.
  - `ecl_kill_m` in the cycle rd=4 is in M -> `rdp_rs1_hit`=0 that cycle, and no write in the following cycle.
- Thread isolation: rd=9 tid=2 in M; query rd=9 tid=0 -> hit=0, data=0.
- Stall: W holds rd=6 and `ecl_stall`=1 for 3 cycles.
  - `rdp_wb_wen`=0 for 3 cycles, then 1 for exactly one cycle.
  - `ecl_kill_m` during the stall clears the held M entry.
- Reset: `reset` pulsed with M and W valid -> next cycle all hits=0, `rdp_wb_wen`=0, all data outputs 0.
